// File: rtl/knn_topk.sv
// rtl/knn_topk.sv - K-nearest-neighbour sorted top-K list with optional majority vote (KNN_VOTE_EN)
module knn_topk #(
    parameter int DATA_W  = 32,
    parameter int K       = 4,
    parameter int LABEL_W = 8,
    parameter int N_CLASS = 10,
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1,
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DATA_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_vld,
    output logic [CNT_W-1:0]   count,
    input  logic               vote_start,
    output logic               vote_busy,
    output logic               vote_valid,
    output logic [LABEL_W-1:0] vote_label
);

    logic [DATA_W-1:0]  e_dist  [K];
    logic [LABEL_W-1:0] e_label [K];
    logic [K-1:0]       e_vld;
    logic [CNT_W-1:0]   cnt;
    logic [K-1:0]       le;
    logic               accept;

    assign accept = in_valid && in_ready;
    assign count  = cnt;

    // Entries that stay ahead of the new sample; ties keep the older sample first
    always_comb begin
        le = '0;
        for (int i = 0; i < K; i++) begin
            le[i] = e_vld[i] && (e_dist[i] <= in_dist);
        end
    end

    // Sorted insert: entries at/after the insert point shift down, the last one falls off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                e_dist[i]  <= '1;
                e_label[i] <= '0;
            end
            e_vld <= '0;
        end else if (clr) begin
            for (int i = 0; i < K; i++) begin
                e_dist[i]  <= '1;
                e_label[i] <= '0;
            end
            e_vld <= '0;
        end else if (accept) begin
            if (!le[0]) begin
                e_dist[0]  <= in_dist;
                e_label[0] <= in_label;
                e_vld[0]   <= 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (!le[i]) begin
                    if (le[i-1]) begin
                        e_dist[i]  <= in_dist;
                        e_label[i] <= in_label;
                        e_vld[i]   <= 1'b1;
                    end else begin
                        e_dist[i]  <= e_dist[i-1];
                        e_label[i] <= e_label[i-1];
                        e_vld[i]   <= e_vld[i-1];
                    end
                end
            end
        end
    end

    // Occupancy counter, saturating once the list is full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept && (cnt != CNT_W'(K))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Indexed read; indices beyond the list match no entry and read as empty
    always_comb begin
        rd_dist  = '1;
        rd_label = '0;
        rd_vld   = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (rd_idx == IDX_W'(i) && e_vld[i]) begin
                rd_dist  = e_dist[i];
                rd_label = e_label[i];
                rd_vld   = 1'b1;
            end
        end
    end

`ifdef KNN_VOTE_EN
    localparam int SC_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   vidx;
    logic [SC_W-1:0]    sidx;
    logic [CNT_W-1:0]   tally [N_CLASS];
    logic [LABEL_W-1:0] best;
    logic [CNT_W-1:0]   best_cnt;
    logic [CNT_W-1:0]   cur_tally;
    logic [LABEL_W-1:0] ent_label;
    logic               ent_vld;
    logic               scan_win;

    assign in_ready = !vote_busy;

    // Entry under the COUNT pointer and tally under the SCAN pointer
    always_comb begin
        ent_label = '0;
        ent_vld   = 1'b0;
        cur_tally = '0;
        for (int i = 0; i < K; i++) begin
            if (vidx == IDX_W'(i)) begin
                ent_label = e_label[i];
                ent_vld   = e_vld[i];
            end
        end
        for (int c = 0; c < N_CLASS; c++) begin
            if (sidx == SC_W'(c)) begin
                cur_tally = tally[c];
            end
        end
    end

    // Strictly greater keeps the lower class on equal tallies
    assign scan_win = cur_tally > best_cnt;

    // Vote FSM: tally labels over the list, then scan tallies for the maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            vidx       <= '0;
            sidx       <= '0;
            best       <= '0;
            best_cnt   <= '0;
            vote_busy  <= 1'b0;
            vote_valid <= 1'b0;
            vote_label <= '0;
            for (int c = 0; c < N_CLASS; c++) begin
                tally[c] <= '0;
            end
        end else if (clr) begin
            state      <= S_IDLE;
            vote_busy  <= 1'b0;
            vote_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    vote_valid <= 1'b0;
                    if (vote_start && (cnt != '0)) begin
                        state     <= S_COUNT;
                        vote_busy <= 1'b1;
                        vidx      <= '0;
                        for (int c = 0; c < N_CLASS; c++) begin
                            tally[c] <= '0;
                        end
                    end
                end
                S_COUNT: begin
                    for (int c = 0; c < N_CLASS; c++) begin
                        if (ent_vld && ent_label == LABEL_W'(c)) begin
                            tally[c] <= tally[c] + 1'b1;
                        end
                    end
                    if (vidx == IDX_W'(K - 1)) begin
                        state    <= S_SCAN;
                        sidx     <= '0;
                        best     <= '0;
                        best_cnt <= '0;
                    end else begin
                        vidx <= vidx + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_win) begin
                        best     <= LABEL_W'(sidx);
                        best_cnt <= cur_tally;
                    end
                    if (sidx == SC_W'(N_CLASS - 1)) begin
                        state      <= S_DONE;
                        vote_valid <= 1'b1;
                        vote_label <= scan_win ? LABEL_W'(sidx) : best;
                    end else begin
                        sidx <= sidx + 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    vote_busy  <= 1'b0;
                    vote_valid <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    vote_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_vote_start;

    assign unused_vote_start = vote_start;
    assign in_ready          = 1'b1;
    assign vote_busy         = 1'b0;
    assign vote_valid        = 1'b0;
    assign vote_label        = '0;
`endif

endmodule

// File: doc/knn_topk.md
Name: knn_topk

Overview:
- Receiving end of the distance stream produced by the KNN distance datapath.
- Accepts one (squared distance, class label) pair per cycle and keeps the K smallest distances in an ascending sorted register list.
- Software and the top-level read the list back through an indexed read port.
- An optional majority-vote FSM turns the final list into a classification result.

Parameters:
- DATA_W, 32: width of the incoming squared distance.
- K, 4: number of nearest neighbours retained (K >= 1).
- LABEL_W, 8: width of the class label attached to each sample.
- N_CLASS, 10: number of valid classes (labels 0..N_CLASS-1); used by the vote only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous list clear, one-cycle pulse.
- in_valid  in  1  a sample is offered this cycle.
- in_ready  out  1  the block accepts a sample this cycle.
- in_dist  in  DATA_W  squared distance of the offered sample.
- in_label  in  LABEL_W  class label of the offered sample.
- rd_idx  in  clog2(K) (min 1)  list entry to read.
- rd_dist  out  DATA_W  distance of entry rd_idx.
- rd_label  out  LABEL_W  label of entry rd_idx.
- rd_vld  out  1  entry rd_idx holds a sample.
- count  out  clog2(K+1)  number of occupied entries, saturating at K.
- vote_start  in  1  start the majority vote (KNN_VOTE_EN).
- vote_busy  out  1  vote FSM active.
- vote_valid  out  1  one-cycle pulse, vote_label valid.
- vote_label  out  LABEL_W  winning class.

Behaviour:
- Reset (rst=0, asynchronous):
  - every entry: dist = all ones, label = 0, vld = 0.
  - count = 0, vote_busy = 0, vote_valid = 0, vote_label = 0.
  - in_ready = 1 after release.
- Handshake:
  - A sample transfers when in_valid && in_ready.
  - in_ready = !vote_busy. Without the feature, in_ready is constant 1 out of reset.
- Insertion (single cycle, all comparisons in parallel):
  - pos = number of occupied entries whose dist <= in_dist. Ties keep the earlier sample ahead.
  - If pos < K: entries pos..K-2 shift down by one, the sample is written at pos, and the old entry K-1 is discarded.
  - If pos == K (list full and in_dist >= entry[K-1].dist): the sample is dropped and no state changes.
  - count increments, saturating at K.
  - Updated list is visible on the read port the cycle after acceptance.
- Ordering invariants:
  - entry[0] holds the nearest sample.
  - Occupied entries are contiguous from index 0 and non-decreasing in dist.
- Read port:
  - Purely combinational from the list registers.
  - An unoccupied entry reads dist = all ones, label = 0, vld = 0.
  - rd_idx >= K reads as unoccupied.
- clr:
  - Next cycle the list returns to reset values and count = 0.
  - clr together with an accepted sample: clr wins and the sample is lost.
  - clr during a vote: the vote aborts to IDLE, with no vote_valid pulse.
- Arithmetic: unsigned distance compare across full DATA_W. An all-ones input distance is legal and is stored when there is space.

Optional Feature:
- Macro: KNN_VOTE_EN.
- With KNN_VOTE_EN defined, a vote FSM with states IDLE, COUNT, SCAN, DONE:
  - IDLE -> COUNT on vote_start when count > 0. vote_start with count == 0 is ignored.
  - COUNT: K cycles, idx 0..K-1. Each occupied entry with label < N_CLASS increments its class tally; other labels are ignored.
  - SCAN: N_CLASS cycles, tracking the maximum tally. On equal tallies the lower class index wins.
  - DONE: 1 cycle. vote_valid = 1 and vote_label = winner (held until the next vote completes), then back to IDLE.
  - vote_busy = 1 in COUNT, SCAN and DONE. Total latency from vote_start to vote_valid is K+N_CLASS+1 cycles.
  - If every valid entry has an out-of-range label, the result is class 0.
  - Tallies are cleared on entry to COUNT.
- Without KNN_VOTE_EN:
  - vote_start is ignored.
  - vote_busy, vote_valid and vote_label are tied to 0, and no FSM or tally logic is synthesised.

Test Plan:
- Reset, then read all indices -> count=0, rd_vld=0, rd_dist=32'hFFFFFFFF for idx 0..3, in_ready=1.
- Insert dist 50,10,30,20 (labels 5,1,3,2) -> entries 10/1, 20/2, 30/3, 50/5, count=4.
- Continue with 25 (label 7), then 60 (label 8) -> list 10,20,25,30 (50 evicted); 60 dropped with no change.
- Tie: full list 10,20,25,30, insert 20 label 9 -> list 10,20(label 2),20(label 9),25; then clr concurrent with in_valid (dist 1) -> count=0, all entries empty.
- KNN_VOTE_EN: list labels 3,3,1,1 with vote_start -> vote_busy high, vote_valid pulse exactly 15 cycles later, vote_label=1 (lower-index tie), in_ready=0 throughout.
- KNN_VOTE_EN: vote_start with count=0 -> no busy; assert clr mid-COUNT -> FSM to IDLE, no vote_valid; assert rst mid-SCAN -> all outputs at reset values immediately.
